// File: rtl/bcd_bin.sv
// Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble.
// Optional input digit checking is enabled by defining BCD_BIN_CHECK_EN.
module bcd_bin (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] BCD_IN,
  output logic [13:0] BIN_OUT,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, SHIFT, ADJ, DONE} state_t;

  state_t      state_q, state_d;
  logic [29:0] work_q, work_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [13:0] bin_out_q, bin_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
`ifdef BCD_BIN_CHECK_EN
  logic        err_q, err_d;
  logic        inval_q, inval_d;
`endif

  // Undo the shift-in +3 of double-dabble: a digit that reached 8 or more
  // after a right shift carried a 1 in from the digit above.
  function automatic logic [15:0] adj_digits(input logic [15:0] b);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd8) ? b[4*i +: 4] - 4'd3 : b[4*i +: 4];
    return r;
  endfunction

`ifdef BCD_BIN_CHECK_EN
  function automatic logic digits_invalid(input logic [15:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++)
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
    return bad;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    bin_out_d = bin_out_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef BCD_BIN_CHECK_EN
    err_d     = err_q;
    inval_d   = inval_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = {BCD_IN, 14'd0};
          cnt_d   = 4'd0;
          busy_d  = 1'b1;
          state_d = SHIFT;
`ifdef BCD_BIN_CHECK_EN
          inval_d = digits_invalid(BCD_IN);
          if (inval_d) state_d = DONE;
`endif
        end
      end
      SHIFT: begin
        work_d  = work_q >> 1;
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'd13) ? DONE : ADJ;
      end
      ADJ: begin
        work_d  = {adj_digits(work_q[29:14]), work_q[13:0]};
        state_d = SHIFT;
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
`ifdef BCD_BIN_CHECK_EN
        if (inval_q) begin
          err_d = 1'b1;
        end else begin
          bin_out_d = work_q[13:0];
          err_d     = 1'b0;
        end
`else
        bin_out_d = work_q[13:0];
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      work_q    <= '0;
      cnt_q     <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BCD_BIN_CHECK_EN
      err_q     <= 1'b0;
      inval_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      bin_out_q <= bin_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BCD_BIN_CHECK_EN
      err_q     <= err_d;
      inval_q   <= inval_d;
`endif
    end
  end

  assign BIN_OUT = bin_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
`ifdef BCD_BIN_CHECK_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: doc/bcd_bin.md
BCD_BIN -- requirements
Module: bcd_bin

Interface
REQ-001 Parameters: none; widths fixed at 4 BCD digits in, 14 binary bits out.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a conversion of BCD_IN; sampled only in IDLE.
REQ-005 BCD_IN  input  16  4-digit packed BCD operand; digit 0 is [3:0], digit 3 is [15:12].
REQ-006 BIN_OUT  output  14  registered binary result, range 0..9999, held between conversions.
REQ-007 busy  output  1  high while a conversion is in progress.
REQ-008 done  output  1  one-cycle pulse when BIN_OUT is updated.
REQ-009 err  output  1  registered invalid-digit flag; see Configuration.

Function
REQ-010 Algorithm SHALL be reverse double-dabble: 30-bit working register {BCD[15:0], BIN[13:0]}, 14 right shifts, and adjust steps between shifts.
REQ-011 FSM states SHALL be IDLE, SHIFT, ADJ, DONE.
REQ-012 IDLE: start=1 at edge E0 -> load BCD <= BCD_IN, BIN <= 0, counter <= 0, busy <= 1, go to SHIFT; start=0 -> stay.
REQ-013 SHIFT: {BCD,BIN} <= {BCD,BIN} >> 1 with zero fill, counter <= counter+1; if counter==13 before increment, go to DONE, else go to ADJ.
REQ-014 ADJ: each BCD digit independently, digit >= 8 -> digit - 3 (4-bit, no borrow across digits), else unchanged; BIN unchanged; go to SHIFT.
REQ-015 DONE: BIN_OUT <= BIN, done <= 1, busy <= 0, go to IDLE.
REQ-016 Timing: start sampled at E0; shifts at E1, E3, ..., E27; adjusts at E2, E4, ..., E26; BIN_OUT, done and busy=0 update at E28. Fixed latency is 28 cycles and is data-independent.
REQ-017 done SHALL be high for exactly one cycle, E28 to E29.
REQ-018 start while busy=1 SHALL be ignored, with no queueing.
REQ-019 start high in the cycle after E28 (state IDLE) SHALL be accepted, so back-to-back conversions are possible every 29 cycles.
REQ-020 BIN_OUT SHALL change only at a DONE edge; BCD_IN changes after E0 SHALL NOT affect the result in progress.
REQ-021 counter SHALL be 4 bits and SHALL never exceed 14.

Reset
REQ-022 reset=1 SHALL immediately force state=IDLE, BIN_OUT=0, busy=0, done=0, err=0, counter=0, and working register=0, independent of clk.
REQ-023 Reset during a conversion SHALL abort it: no done pulse, and BIN_OUT stays 0 after release.
REQ-024 The first start SHALL be accepted at the first rising edge after reset deasserts.

Configuration
REQ-025 Macro BCD_BIN_CHECK_EN controls input digit checking.
REQ-026 With BCD_BIN_CHECK_EN defined: if any BCD_IN digit > 9 when start is accepted at E0, skip SHIFT/ADJ and go directly to DONE. At E1: done=1, err=1, busy=0, BIN_OUT unchanged.
REQ-027 With BCD_BIN_CHECK_EN defined: a valid conversion SHALL clear err at its DONE edge.
REQ-028 Without BCD_BIN_CHECK_EN: err is tied to 0, no check logic is generated, and invalid digits run the normal 28-cycle sequence with an unspecified BIN_OUT.

Verification
REQ-029 BCD_IN=16'h1234, start pulse -> done exactly 28 cycles later, BIN_OUT=14'd1234 (0x04D2), err=0.
REQ-030 BCD_IN=16'h9999 then 16'h0000, back-to-back starts -> BIN_OUT=9999 (0x270F), then 0; done pulses 29 cycles apart.
REQ-031 Start at E0 with 16'h0500; pulse start at E5 with BCD_IN=16'h0007 -> single done at E28, BIN_OUT=500.
REQ-032 Start 16'h8765, assert reset at E10 for 2 cycles -> no done; BIN_OUT=0, busy=0; a new start with 16'h0042 then yields 42.
REQ-033 With BCD_BIN_CHECK_EN defined: BCD_IN=16'h12A4 -> done and err at E1, BIN_OUT keeps its prior value; a following 16'h0001 -> err=0, BIN_OUT=1.
REQ-034 Exhaustive sweep 0000..9999 -> BIN_OUT equals the decimal value for every input.
